// File: rtl/ahb_arbiter.sv
// rtl/ahb_arbiter.sv - two-master AHB-Lite arbiter onto one slave port
// Grants one address phase per cycle, routes the data phase by owner, buffers stalled completions.
module ahb_arbiter #(
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic [31:0] M0_HADDR,
   input  logic        M0_HWRITE,
   input  logic [1:0]  M0_HTRANS,
   input  logic [31:0] M0_HWDATA,
   output logic [31:0] M0_HRDATA,
   output logic        M0_HREADY,
   output logic        M0_HRESP,
   input  logic [31:0] M1_HADDR,
   input  logic        M1_HWRITE,
   input  logic [1:0]  M1_HTRANS,
   input  logic [31:0] M1_HWDATA,
   output logic [31:0] M1_HRDATA,
   output logic        M1_HREADY,
   output logic        M1_HRESP,
   output logic [31:0] HADDR,
   output logic        HWRITE,
   output logic [1:0]  HTRANS,
   output logic [31:0] HWDATA,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP
);

   localparam logic [1:0] TR_IDLE = 2'b00;
   localparam logic [1:0] TR_BUSY = 2'b01;
   localparam logic [1:0] TR_SEQ  = 2'b11;

   logic [1:0]        gnt_d, gnt_q;
   logic              rr_last_d, rr_last_q;
   logic              data_own_d, data_own_q;
   logic              data_vld_d, data_vld_q;
   logic [1:0]        buf_vld_d, buf_vld_q;
   logic [1:0][31:0]  buf_rdata_d, buf_rdata_q;
   logic [1:0]        buf_resp_d, buf_resp_q;

   logic [1:0][31:0]  m_haddr, m_hwdata, mst_rdata;
   logic [1:0][1:0]   m_htrans;
   logic [1:0]        m_hwrite, req, mst_ready, mst_resp, own;
   logic              lock, gnt_idx, addr_sel, issue;

   assign m_haddr  = {M1_HADDR, M0_HADDR};
   assign m_hwdata = {M1_HWDATA, M0_HWDATA};
   assign m_htrans = {M1_HTRANS, M0_HTRANS};
   assign m_hwrite = {M1_HWRITE, M0_HWRITE};
   assign req      = {M1_HTRANS[1], M0_HTRANS[1]};

   // A burst in progress (SEQ or BUSY) keeps the bus with the master that issued last.
   assign lock = (m_htrans[rr_last_q] == TR_SEQ) || (m_htrans[rr_last_q] == TR_BUSY);

   always_comb begin
      gnt_d = gnt_q;
      if (HREADY) begin
         if (lock)
            gnt_d = rr_last_q ? 2'b10 : 2'b01;
         else if (&req)
            gnt_d = (FIXED_PRIO || rr_last_q) ? 2'b01 : 2'b10;
         else if (req[0])
            gnt_d = 2'b01;
         else if (req[1])
            gnt_d = 2'b10;
         else
            gnt_d = 2'b00;
      end
   end

   assign gnt_idx  = gnt_d[1];
   assign addr_sel = (|gnt_d) ? gnt_idx : rr_last_q;
   assign HADDR    = m_haddr[addr_sel];
   assign HWRITE   = m_hwrite[addr_sel];
   assign HTRANS   = (|gnt_d) ? m_htrans[gnt_idx] : TR_IDLE;
   assign issue    = HREADY && (|gnt_d) && m_htrans[gnt_idx][1];
   assign HWDATA   = data_vld_q ? m_hwdata[data_own_q] : 32'h0;

   always_comb begin
      rr_last_d   = rr_last_q;
      data_own_d  = data_own_q;
      data_vld_d  = data_vld_q;
      if (HREADY) begin
         data_vld_d = issue;
         if (issue) begin
            rr_last_d  = gnt_idx;
            data_own_d = gnt_idx;
         end
      end
   end

   always_comb begin
      buf_vld_d   = buf_vld_q;
      buf_rdata_d = buf_rdata_q;
      buf_resp_d  = buf_resp_q;
      own         = 2'b00;
      mst_ready   = 2'b11;
      mst_rdata   = '0;
      mst_resp    = 2'b00;
      for (int x = 0; x < 2; x++) begin
         own[x] = data_vld_q && (data_own_q == 1'(x));
         if (gnt_d[x])
            mst_ready[x] = HREADY;
         else if (req[x])
            mst_ready[x] = 1'b0;
         else if (own[x])
            mst_ready[x] = HREADY;
         else
            mst_ready[x] = 1'b1;

         mst_rdata[x] = buf_vld_q[x] ? buf_rdata_q[x] : HRDATA;
         mst_resp[x]  = buf_vld_q[x] ? buf_resp_q[x] : (own[x] && HRESP);

         // A stalled master cannot see its completion now, so hold it until its HREADY rises.
         if (HREADY && own[x] && req[x] && !gnt_d[x]) begin
            buf_vld_d[x]   = 1'b1;
            buf_rdata_d[x] = HRDATA;
            buf_resp_d[x]  = HRESP;
         end else if (mst_ready[x]) begin
            buf_vld_d[x] = 1'b0;
         end
      end
   end

   assign M0_HREADY = mst_ready[0];
   assign M1_HREADY = mst_ready[1];
   assign M0_HRDATA = mst_rdata[0];
   assign M1_HRDATA = mst_rdata[1];
   assign M0_HRESP  = mst_resp[0];
   assign M1_HRESP  = mst_resp[1];

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         gnt_q       <= 2'b00;
         rr_last_q   <= 1'b1;
         data_own_q  <= 1'b0;
         data_vld_q  <= 1'b0;
         buf_vld_q   <= 2'b00;
         buf_rdata_q <= '0;
         buf_resp_q  <= 2'b00;
      end else begin
         gnt_q       <= gnt_d;
         rr_last_q   <= rr_last_d;
         data_own_q  <= data_own_d;
         data_vld_q  <= data_vld_d;
         buf_vld_q   <= buf_vld_d;
         buf_rdata_q <= buf_rdata_d;
         buf_resp_q  <= buf_resp_d;
      end
   end

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb/tb_ahb_arbiter.sv - scoreboard bench for ahb_arbiter
// Directed per-cycle vectors; expected outputs queued by the driver, checked by a negedge monitor.
module tb_ahb_arbiter;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic [31:0] M0_HADDR, M1_HADDR, M0_HWDATA, M1_HWDATA;
   logic        M0_HWRITE, M1_HWRITE;
   logic [1:0]  M0_HTRANS, M1_HTRANS;
   logic [31:0] M0_HRDATA, M1_HRDATA;
   logic        M0_HREADY, M1_HREADY, M0_HRESP, M1_HRESP;
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic        HWRITE, HREADY, HRESP;
   logic [1:0]  HTRANS;

   always #5 HCLK = ~HCLK;

   ahb_arbiter dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .M0_HADDR(M0_HADDR), .M0_HWRITE(M0_HWRITE), .M0_HTRANS(M0_HTRANS), .M0_HWDATA(M0_HWDATA),
      .M0_HRDATA(M0_HRDATA), .M0_HREADY(M0_HREADY), .M0_HRESP(M0_HRESP),
      .M1_HADDR(M1_HADDR), .M1_HWRITE(M1_HWRITE), .M1_HTRANS(M1_HTRANS), .M1_HWDATA(M1_HWDATA),
      .M1_HRDATA(M1_HRDATA), .M1_HREADY(M1_HREADY), .M1_HRESP(M1_HRESP),
      .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS), .HWDATA(HWDATA),
      .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
   );

   typedef struct {
      string       tag;
      logic [1:0]  t;
      logic [31:0] a;
      logic        w;
      logic [31:0] wd;
      logic        r0, r1, e0, e1;
      logic [31:0] d0, d1;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   int   n_vec  = 0;
   int   n_miss = 0;

   task automatic cmp(input string tag, input string nm, input logic [31:0] act, input logic [31:0] want);
      if (act !== want) begin
         n_miss++;
         $display("FAIL %s %s: got %h want %h", tag, nm, act, want);
      end
   endtask

   always @(negedge HCLK) begin
      if (exp_q.size() != 0) begin
         cur = exp_q.pop_front();
         n_vec++;
         cmp(cur.tag, "HTRANS",    {30'h0, HTRANS},    {30'h0, cur.t});
         cmp(cur.tag, "HADDR",     HADDR,              cur.a);
         cmp(cur.tag, "HWRITE",    {31'h0, HWRITE},    {31'h0, cur.w});
         cmp(cur.tag, "HWDATA",    HWDATA,             cur.wd);
         cmp(cur.tag, "M0_HREADY", {31'h0, M0_HREADY}, {31'h0, cur.r0});
         cmp(cur.tag, "M1_HREADY", {31'h0, M1_HREADY}, {31'h0, cur.r1});
         cmp(cur.tag, "M0_HRESP",  {31'h0, M0_HRESP},  {31'h0, cur.e0});
         cmp(cur.tag, "M1_HRESP",  {31'h0, M1_HRESP},  {31'h0, cur.e1});
         cmp(cur.tag, "M0_HRDATA", M0_HRDATA,          cur.d0);
         cmp(cur.tag, "M1_HRDATA", M1_HRDATA,          cur.d1);
      end
   end

   task automatic m0(input logic [31:0] a, input logic w, input logic [1:0] t, input logic [31:0] wd);
      M0_HADDR = a; M0_HWRITE = w; M0_HTRANS = t; M0_HWDATA = wd;
   endtask

   task automatic m1(input logic [31:0] a, input logic w, input logic [1:0] t, input logic [31:0] wd);
      M1_HADDR = a; M1_HWRITE = w; M1_HTRANS = t; M1_HWDATA = wd;
   endtask

   task automatic slv(input logic [31:0] rd, input logic rdy, input logic resp);
      HRDATA = rd; HREADY = rdy; HRESP = resp;
   endtask

   // Queue the expected outputs for the current input set, then advance one cycle.
   task automatic ex(input string tag, input logic [1:0] t, input logic [31:0] a, input logic w,
                     input logic [31:0] wd, input logic r0, input logic r1, input logic e0,
                     input logic e1, input logic [31:0] d0, input logic [31:0] d1);
      exp_t e;
      e.tag = tag; e.t = t; e.a = a; e.w = w; e.wd = wd;
      e.r0 = r0; e.r1 = r1; e.e0 = e0; e.e1 = e1; e.d0 = d0; e.d1 = d1;
      exp_q.push_back(e);
      @(posedge HCLK);
      #1;
   endtask

   task automatic do_reset(input string tag, input logic [31:0] rd);
      HRESETn = 1'b0;
      m0(32'h0, 1'b0, 2'b00, 32'h0);
      m1(32'h0, 1'b0, 2'b00, 32'h0);
      slv(rd, 1'b1, 1'b0);
      ex(tag, 2'b00, 32'h0, 1'b0, 32'h0, 1, 1, 0, 0, rd, rd);
      HRESETn = 1'b1;
   endtask

   initial begin
      HRESETn = 1'b0;
      m0(32'h0, 1'b0, 2'b00, 32'h0);
      m1(32'h0, 1'b0, 2'b00, 32'h0);
      slv(32'h0, 1'b1, 1'b0);
      @(posedge HCLK);
      #1;
      do_reset("reset", 32'h0);

      // Uncontested read
      m0(32'h10, 0, 2'b10, 0);
      ex("rd_a", 2'b10, 32'h10, 0, 0, 1, 1, 0, 0, 32'h0, 32'h0);
      m0(32'h0, 0, 2'b00, 0); slv(32'hDEADBEEF, 1, 0);
      ex("rd_d", 2'b00, 32'h0, 0, 0, 1, 1, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF);

      // Round-robin tie right after reset: M0 first
      do_reset("reset2", 32'h0);
      m0(32'h100, 1, 2'b10, 32'h11); m1(32'h200, 1, 2'b10, 32'h22);
      ex("tie_a", 2'b10, 32'h100, 1, 32'h0, 1, 0, 0, 0, 0, 0);
      m0(32'h0, 0, 2'b00, 32'h11);
      ex("tie_b", 2'b10, 32'h200, 1, 32'h11, 1, 1, 0, 0, 0, 0);
      m1(32'h0, 0, 2'b00, 32'h22);
      ex("tie_c", 2'b00, 32'h0, 0, 32'h22, 1, 1, 0, 0, 0, 0);

      // Buffered completion
      m0(32'h30, 0, 2'b10, 0); m1(32'h0, 0, 2'b00, 0); slv(32'h0, 1, 0);
      ex("buf_a", 2'b10, 32'h30, 0, 0, 1, 1, 0, 0, 0, 0);
      m0(32'h34, 0, 2'b10, 0); m1(32'h40, 0, 2'b10, 0); slv(32'hAAAA0001, 1, 0);
      ex("buf_b", 2'b10, 32'h40, 0, 0, 0, 1, 0, 0, 32'hAAAA0001, 32'hAAAA0001);
      m1(32'h0, 0, 2'b00, 0); slv(32'hBBBB0002, 1, 0);
      ex("buf_c", 2'b10, 32'h34, 0, 0, 1, 1, 0, 0, 32'hAAAA0001, 32'hBBBB0002);
      m0(32'h0, 0, 2'b00, 0); slv(32'hCCCC0003, 1, 0);
      ex("buf_d", 2'b00, 32'h0, 0, 0, 1, 1, 0, 0, 32'hCCCC0003, 32'hCCCC0003);

      // Burst lock: M1 NONSEQ, SEQ, BUSY, SEQ, SEQ while M0 waits
      slv(32'h0, 1, 0);
      m0(32'h600, 0, 2'b10, 0); m1(32'h500, 0, 2'b10, 32'h55);
      ex("lk_a", 2'b10, 32'h500, 0, 32'h0, 0, 1, 0, 0, 0, 0);
      m1(32'h504, 0, 2'b11, 32'h55);
      ex("lk_b", 2'b11, 32'h504, 0, 32'h55, 0, 1, 0, 0, 0, 0);
      m1(32'h508, 0, 2'b01, 32'h55);
      ex("lk_c", 2'b01, 32'h508, 0, 32'h55, 0, 1, 0, 0, 0, 0);
      m1(32'h508, 0, 2'b11, 32'h55);
      ex("lk_d", 2'b11, 32'h508, 0, 32'h0, 0, 1, 0, 0, 0, 0);
      m1(32'h50C, 0, 2'b11, 32'h55);
      ex("lk_e", 2'b11, 32'h50C, 0, 32'h55, 0, 1, 0, 0, 0, 0);
      m1(32'h0, 0, 2'b00, 32'h55);
      ex("lk_f", 2'b10, 32'h600, 0, 32'h55, 1, 1, 0, 0, 0, 0);
      m0(32'h0, 0, 2'b00, 0);
      ex("lk_g", 2'b00, 32'h0, 0, 32'h0, 1, 1, 0, 0, 0, 0);

      // Three wait states freeze the grant and address
      m1(32'h0, 0, 2'b00, 0);
      m0(32'h700, 0, 2'b10, 0);
      ex("ws_a", 2'b10, 32'h700, 0, 0, 1, 1, 0, 0, 0, 0);
      m0(32'h704, 0, 2'b10, 0); m1(32'h800, 0, 2'b10, 0); slv(32'h0, 0, 0);
      for (int i = 0; i < 3; i++)
         ex("ws_wait", 2'b10, 32'h704, 0, 0, 0, 0, 0, 0, 0, 0);
      slv(32'h7777, 1, 0);
      ex("ws_e", 2'b10, 32'h800, 0, 0, 0, 1, 0, 0, 32'h7777, 32'h7777);
      m1(32'h0, 0, 2'b00, 0); slv(32'h8888, 1, 0);
      ex("ws_f", 2'b10, 32'h704, 0, 0, 1, 1, 0, 0, 32'h7777, 32'h8888);
      m0(32'h0, 0, 2'b00, 0); slv(32'h9999, 1, 0);
      ex("ws_g", 2'b00, 32'h0, 0, 0, 1, 1, 0, 0, 32'h9999, 32'h9999);

      // ERROR delivered to a stalled master through the buffer
      slv(32'h0, 1, 0);
      m0(32'h900, 0, 2'b10, 0);
      ex("er_a", 2'b10, 32'h900, 0, 0, 1, 1, 0, 0, 0, 0);
      m0(32'h904, 0, 2'b10, 0); m1(32'hA00, 0, 2'b10, 0); slv(32'h0, 0, 1);
      ex("er_b", 2'b10, 32'h904, 0, 0, 0, 0, 1, 0, 0, 0);
      slv(32'h0, 1, 1);
      ex("er_c", 2'b10, 32'hA00, 0, 0, 0, 1, 1, 0, 0, 0);
      m1(32'h0, 0, 2'b00, 0); slv(32'h0, 1, 0);
      ex("er_d", 2'b10, 32'h904, 0, 0, 1, 1, 1, 0, 0, 0);
      m0(32'h0, 0, 2'b00, 0);
      ex("er_e", 2'b00, 32'h0, 0, 0, 1, 1, 0, 0, 0, 0);

      // Reset mid-burst with a buffered M1 response pending
      m1(32'hC00, 0, 2'b10, 0);
      ex("rs_a", 2'b10, 32'hC00, 0, 0, 1, 1, 0, 0, 0, 0);
      m0(32'hB00, 0, 2'b10, 0); m1(32'hC04, 0, 2'b10, 0); slv(32'hBEEF, 1, 0);
      ex("rs_b", 2'b10, 32'hB00, 0, 0, 1, 0, 0, 0, 32'hBEEF, 32'hBEEF);
      m0(32'hB04, 0, 2'b11, 0); slv(32'h1111, 1, 0);
      ex("rs_c", 2'b11, 32'hB04, 0, 0, 1, 0, 0, 0, 32'h1111, 32'hBEEF);
      do_reset("rs_rst", 32'h2222);
      m0(32'hD00, 1, 2'b10, 32'hD0); m1(32'hE00, 1, 2'b10, 32'hE0); slv(32'h0, 1, 0);
      ex("rs_e", 2'b10, 32'hD00, 1, 0, 1, 0, 0, 0, 0, 0);
      m0(32'h0, 0, 2'b00, 32'hD0);
      ex("rs_f", 2'b10, 32'hE00, 1, 32'hD0, 1, 1, 0, 0, 0, 0);
      m1(32'h0, 0, 2'b00, 32'hE0);
      ex("rs_g", 2'b00, 32'h0, 0, 32'hE0, 1, 1, 0, 0, 0, 0);

      @(negedge HCLK);
      if (exp_q.size() != 0) begin
         n_miss++;
         $display("FAIL drain: got %0d unchecked want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Two-master AHB-Lite arbiter that shares the single `ahb_matrix` slave port between two requesters, for example the schoolMIPS core data port (M0) and a DMA/ETH engine (M1). It forwards exactly one master's address phase per bus cycle and stalls the other master through its own HREADY. It routes HWDATA, HRDATA and HRESP according to the registered data-phase owner. When a stalled master's previous data phase completes, its response is buffered so that no completion is lost.

## Interface
- FIXED_PRIO, 0: 0 = round-robin; 1 = M0 always wins ties (burst lock still applies)

Ports:
- HCLK  in  1  bus clock
- HRESETn  in  1  Reset is asynchronous and active-low.
- M0_HADDR, M1_HADDR  in  32  master address
- M0_HWRITE, M1_HWRITE  in  1  master write
- M0_HTRANS, M1_HTRANS  in  2  master transfer type (IDLE 00, BUSY 01, NONSEQ 10, SEQ 11)
- M0_HWDATA, M1_HWDATA  in  32  master write data
- M0_HRDATA, M1_HRDATA  out  32  read data to master
- M0_HREADY, M1_HREADY  out  1  ready to master
- M0_HRESP, M1_HRESP  out  1  response to master
- HADDR, HWRITE, HTRANS, HWDATA  out  32/1/2/32  to matrix
- HRDATA, HREADY, HRESP  in  32/1/1  from matrix

## Operation
**Requests and burst lock**
- A master requests when `Mx_HTRANS[1]` = 1.
- `lock` = `Mx_HTRANS` of the last-issued master is SEQ or BUSY.

**Grant**
- `gnt` is one-hot or none.
- While bus HREADY = 0: `gnt` = `gnt_q`. The registered grant is held, so the forwarded address phase never changes mid-wait.
- While bus HREADY = 1, priority order:
  - `lock`: the last-issued master.
  - Both masters request: the master that is not `rr_last` (FIXED_PRIO = 1: M0).
  - One master requests: that master.
  - Otherwise none.
- `gnt_q` <= `gnt` every cycle.

**Address forwarding**
- HADDR and HWRITE come from the granted master; when none is granted, they are parked on `rr_last`.
- HTRANS = granted master's HTRANS, else IDLE.

**Issue**
- A transfer issues when bus HREADY = 1 and the granted HTRANS ≠ IDLE/BUSY.
- On issue: `rr_last` <= index, `data_own` <= index, `data_vld` <= 1.
- HREADY = 1 with no issue: `data_vld` <= 0.

**Data routing**
- HWDATA = `Mx_HWDATA` of `data_own` when `data_vld`, else 0.

**Master HREADY, per master x**
- x granted: `Mx_HREADY` = bus HREADY.
- x requesting but not granted: `Mx_HREADY` = 0 (stall).
- x not requesting and owns the data phase: `Mx_HREADY` = bus HREADY.
- Otherwise: `Mx_HREADY` = 1.

**Response buffer, per master (`buf_vld`, `buf_rdata`, `buf_resp`)**
- Capture: bus HREADY = 1, `data_vld`, `data_own` = x, and x stalled → `buf_vld` <= 1; latch HRDATA and HRESP.
- Release: `buf_vld` clears on the first cycle `Mx_HREADY` = 1. That cycle completes both the buffered data phase and the new address phase.
- `Mx_HRDATA` = `buf_vld` ? `buf_rdata` : HRDATA.
- `Mx_HRESP` = `buf_vld` ? `buf_resp` : (`data_vld` and `data_own` = x ? HRESP : 0).
- A buffered ERROR therefore holds HRESP = 1 with HREADY low for ≥1 cycle, then with HREADY high. This preserves two-cycle ERROR semantics.

**Write data**
- Masters hold HWDATA while their HREADY is low, so write data is valid in the bus completion cycle; no HWDATA buffer is needed.

## Timing
**Reset**
- `gnt_q` = none, `data_vld` = 0, both `buf_vld` = 0, `rr_last` = 1 (M0 wins the first tie).
- With both masters IDLE after reset: HTRANS = 00, HWDATA = 0, `Mx_HREADY` = 1, `Mx_HRESP` = 0.
- Reset mid-transfer clears all state immediately; buffered responses are discarded.

**Latency**
- Zero added latency for an uncontested master: the address is forwarded in the same cycle and the response is combinational.

**Contention**
- The loser waits ≥1 cycle.
- A locked burst is never interrupted; the other master is granted at the first HREADY = 1 cycle whose owner HTRANS is NONSEQ or IDLE.

**Boundary cases**
- Simultaneous NONSEQ from both with `rr_last` = 0: M1 is granted first.
- Bus HREADY low for N cycles: grant, HADDR and `data_own` are frozen.
- Capture and release in the same cycle cannot occur: capture requires x to be stalled.

## Test plan
- **Uncontested read.** M0 reads 0x0000_0010, RAM returns 0xDEADBEEF, M1 idle → HADDR = 0x10 in cycle 0; `M0_HRDATA` = 0xDEADBEEF with `M0_HREADY` = 1 in cycle 1; M1 sees HREADY = 1, HRESP = 0 throughout.
- **Round-robin tie.** After reset, both issue NONSEQ writes (M0 data 0x11, M1 data 0x22) → M0 is issued first; M1 stalled one cycle; bus HWDATA = 0x11, then 0x22.
- **Buffered completion.** M0 issues a read, then its next NONSEQ while M1 wins → M0's read data is buffered; `M0_HRDATA` shows the buffered value when `M0_HREADY` rises; buffer clears.
- **Burst lock.** M1 issues 4-beat SEQ (incl. one BUSY) while M0 requests → M0 stalls until the beat after M1's last SEQ.
- **Wait states and ERROR.** Slave inserts 3 wait states → HADDR/`gnt` stable for 3 cycles. Slave ERROR to a stalled master → that master sees HRESP = 1 for ≥2 cycles, HREADY low then high.
- **Reset mid-burst.** HRESETn asserted mid-burst → next cycle HTRANS = IDLE, `buf_vld` = 0, M0 wins the next tie.
